// File: rtl/pid_core_mc_if.sv
// Sample-path bundle for pid_core_mc: tagged samples in (valid/ready),
// tagged clamped PID results out (one-cycle strobe plus saturation flag).
interface pid_core_mc_if #(
  parameter int W_IN  = 18,
  parameter int W_OUT = 32,
  parameter int W_CH  = 3
);
  logic [W_IN-1:0]         data_in;
  logic [W_CH-1:0]         chan_in;
  logic                    data_valid_in;
  logic                    ready_out;
  logic signed [W_OUT-1:0] data_out;
  logic [W_CH-1:0]         chan_out;
  logic                    data_valid_out;
  logic                    sat_out;

  modport master (
    output data_in, chan_in, data_valid_in,
    input  ready_out, data_out, chan_out, data_valid_out, sat_out
  );

  modport slave (
    input  data_in, chan_in, data_valid_in,
    output ready_out, data_out, chan_out, data_valid_out, sat_out
  );
endinterface

// File: rtl/pid_core_mc.sv
// Time-multiplexed velocity-form PID. One shared multiplier serves N_CH
// channels, each with a shadow/active coefficient bank and its own
// e1/e2/u_prev history. One sample is processed every 7 cycles.
module pid_core_mc #(
  parameter int W_IN   = 18,
  parameter int W_OUT  = 32,
  parameter int W_COEF = 16,
  parameter int N_CH   = 8,
  parameter int W_CH   = 3,
  parameter logic signed [W_OUT-1:0] OUT_MAX = {1'b0, {(W_OUT-1){1'b1}}},
  parameter logic signed [W_OUT-1:0] OUT_MIN = {1'b1, {(W_OUT-1){1'b0}}}
) (
  input  logic                     clk_in,
  input  logic                     reset_n_in,
  pid_core_mc_if.slave             bus,
  input  logic [W_CH-1:0]          param_chan_in,
  input  logic signed [W_COEF-1:0] setpoint_in,
  input  logic signed [W_COEF-1:0] p_coef_in,
  input  logic signed [W_COEF-1:0] i_coef_in,
  input  logic signed [W_COEF-1:0] d_coef_in,
  input  logic                     param_wr_in,
  input  logic                     update_in,
  input  logic                     clear_in
);
  localparam int W_E   = W_IN + 2;
  localparam int W_K   = W_COEF + 2;
  localparam int W_P   = W_E + W_K;
  localparam int W_ACC = W_OUT + W_COEF + W_IN + 4;
  localparam logic [W_CH:0] N_CH_L = (W_CH+1)'(N_CH);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MAC0, S_MAC1, S_MAC2, S_SAT, S_SEND
  } state_t;

  typedef struct packed {
    logic signed [W_COEF-1:0] sp;
    logic signed [W_COEF-1:0] kp;
    logic signed [W_COEF-1:0] ki;
    logic signed [W_COEF-1:0] kd;
  } bank_t;

  state_t state_q, state_d;
  logic ready_q, ready_d;
  logic [W_IN-1:0] sample_q, sample_d;
  logic [W_CH-1:0] chan_q, chan_d;
  logic upd_pend_q, upd_pend_d;
  bank_t shadow_q [N_CH];
  bank_t shadow_d [N_CH];
  bank_t active_q [N_CH];
  bank_t active_d [N_CH];
  logic signed [W_E-1:0] e1_hist_q [N_CH];
  logic signed [W_E-1:0] e1_hist_d [N_CH];
  logic signed [W_E-1:0] e2_hist_q [N_CH];
  logic signed [W_E-1:0] e2_hist_d [N_CH];
  logic signed [W_OUT-1:0] u_hist_q [N_CH];
  logic signed [W_OUT-1:0] u_hist_d [N_CH];
  logic signed [W_K-1:0] k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
  logic signed [W_E-1:0] e0_q, e0_d, e1_q, e1_d, e2_q, e2_d;
  logic signed [W_OUT-1:0] u_prev_q, u_prev_d;
  logic signed [W_ACC-1:0] acc_q, acc_d;
  logic signed [W_OUT-1:0] data_out_q, data_out_d;
  logic [W_CH-1:0] chan_out_q, chan_out_d;
  logic dv_q, dv_d, sat_q, sat_d;

  logic accept, chan_ok, param_ok;
  logic [W_CH-1:0] idx;
  bank_t bank;
  logic signed [W_K-1:0] kp_x, ki_x, kd_x;
  logic signed [W_P-1:0] mul_a, mul_b, prod;
  logic signed [W_ACC-1:0] u_full, max_x, min_x;

  assign accept   = bus.data_valid_in & ready_q;
  assign chan_ok  = {1'b0, chan_q} < N_CH_L;
  assign param_ok = {1'b0, param_chan_in} < N_CH_L;
  assign idx      = chan_ok ? chan_q : '0;

  assign bus.ready_out      = ready_q;
  assign bus.data_out       = data_out_q;
  assign bus.chan_out       = chan_out_q;
  assign bus.data_valid_out = dv_q;
  assign bus.sat_out        = sat_q;

  // Sequencer next state; ready is registered so it stays low through reset
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_LOAD;
      S_LOAD:  state_d = chan_ok ? S_MAC0 : S_IDLE;
      S_MAC0:  state_d = S_MAC1;
      S_MAC1:  state_d = S_MAC2;
      S_MAC2:  state_d = S_SAT;
      S_SAT:   state_d = S_SEND;
      S_SEND:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  // Datapath, coefficient banks and per-channel history updates
  always_comb begin
    sample_d = sample_q;      chan_d = chan_q;        upd_pend_d = upd_pend_q;
    shadow_d = shadow_q;      active_d = active_q;
    e1_hist_d = e1_hist_q;    e2_hist_d = e2_hist_q;  u_hist_d = u_hist_q;
    k1_d = k1_q;  k2_d = k2_q;  k3_d = k3_q;
    e0_d = e0_q;  e1_d = e1_q;  e2_d = e2_q;
    u_prev_d = u_prev_q;      acc_d = acc_q;
    data_out_d = data_out_q;  chan_out_d = chan_out_q;
    sat_d = sat_q;            dv_d = 1'b0;
    bank = active_q[idx];
    kp_x = {{2{bank.kp[W_COEF-1]}}, bank.kp};
    ki_x = {{2{bank.ki[W_COEF-1]}}, bank.ki};
    kd_x = {{2{bank.kd[W_COEF-1]}}, bank.kd};
    mul_a = '0;
    mul_b = '0;
    u_full = {{(W_ACC-W_OUT){u_prev_q[W_OUT-1]}}, u_prev_q} + acc_q;
    max_x  = {{(W_ACC-W_OUT){OUT_MAX[W_OUT-1]}}, OUT_MAX};
    min_x  = {{(W_ACC-W_OUT){OUT_MIN[W_OUT-1]}}, OUT_MIN};

    if (state_q == S_IDLE && (upd_pend_q || update_in)) begin
      active_d   = shadow_q;
      upd_pend_d = 1'b0;
    end else if (update_in) begin
      upd_pend_d = 1'b1;
    end
    if (param_wr_in && param_ok)
      shadow_d[param_chan_in] = '{sp: setpoint_in, kp: p_coef_in, ki: i_coef_in, kd: d_coef_in};
    if (accept) begin
      sample_d = bus.data_in;
      chan_d   = bus.chan_in;
    end

    unique case (state_q)
      S_MAC0: begin mul_a = {{(W_P-W_K){k1_q[W_K-1]}}, k1_q}; mul_b = {{(W_P-W_E){e0_q[W_E-1]}}, e0_q}; end
      S_MAC1: begin mul_a = {{(W_P-W_K){k2_q[W_K-1]}}, k2_q}; mul_b = {{(W_P-W_E){e1_q[W_E-1]}}, e1_q}; end
      S_MAC2: begin mul_a = {{(W_P-W_K){k3_q[W_K-1]}}, k3_q}; mul_b = {{(W_P-W_E){e2_q[W_E-1]}}, e2_q}; end
      default: ;
    endcase
    prod = mul_a * mul_b;

    unique case (state_q)
      S_LOAD: begin
        e0_d     = {{(W_E-W_COEF){bank.sp[W_COEF-1]}}, bank.sp} - {2'b00, sample_q};
        k1_d     = kp_x + ki_x + kd_x;
        k2_d     = -kp_x - (kd_x <<< 1);
        k3_d     = kd_x;
        e1_d     = e1_hist_q[idx];
        e2_d     = e2_hist_q[idx];
        u_prev_d = u_hist_q[idx];
        acc_d    = '0;
      end
      S_MAC0, S_MAC1, S_MAC2: acc_d = acc_q + {{(W_ACC-W_P){prod[W_P-1]}}, prod};
      S_SAT: begin
        if (u_full > max_x) begin
          data_out_d = OUT_MAX;
          sat_d      = 1'b1;
        end else if (u_full < min_x) begin
          data_out_d = OUT_MIN;
          sat_d      = 1'b1;
        end else begin
          data_out_d = u_full[W_OUT-1:0];
          sat_d      = 1'b0;
        end
        chan_out_d = chan_q;
        dv_d       = 1'b1;
      end
      S_SEND: begin
        e2_hist_d[idx] = e1_q;
        e1_hist_d[idx] = e0_q;
        u_hist_d[idx]  = data_out_q;
      end
      default: ;
    endcase

    if (clear_in) begin
      for (int c = 0; c < N_CH; c++) begin
        e1_hist_d[c] = '0;
        e2_hist_d[c] = '0;
        u_hist_d[c]  = '0;
      end
    end
  end

  // All state registers; reset aborts any computation in flight
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= S_IDLE;  ready_q <= 1'b0;  sample_q <= '0;  chan_q <= '0;
      upd_pend_q <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        shadow_q[c] <= '0;  active_q[c] <= '0;
        e1_hist_q[c] <= '0; e2_hist_q[c] <= '0; u_hist_q[c] <= '0;
      end
      k1_q <= '0;  k2_q <= '0;  k3_q <= '0;
      e0_q <= '0;  e1_q <= '0;  e2_q <= '0;
      u_prev_q <= '0;  acc_q <= '0;
      data_out_q <= '0;  chan_out_q <= '0;  dv_q <= 1'b0;  sat_q <= 1'b0;
    end else begin
      state_q <= state_d;  ready_q <= ready_d;  sample_q <= sample_d;  chan_q <= chan_d;
      upd_pend_q <= upd_pend_d;
      shadow_q <= shadow_d;  active_q <= active_d;
      e1_hist_q <= e1_hist_d;  e2_hist_q <= e2_hist_d;  u_hist_q <= u_hist_d;
      k1_q <= k1_d;  k2_q <= k2_d;  k3_q <= k3_d;
      e0_q <= e0_d;  e1_q <= e1_d;  e2_q <= e2_d;
      u_prev_q <= u_prev_d;  acc_q <= acc_d;
      data_out_q <= data_out_d;  chan_out_q <= chan_out_d;  dv_q <= dv_d;  sat_q <= sat_d;
    end
  end
endmodule

// File: tb/tb_pid_core_mc.sv
// Bench for pid_core_mc: table of samples with hand-computed velocity-form
// results, scoreboard queue popped on each output strobe, plus hand-written
// sequences for commit timing, back-to-back handshake, bad channel, clear
// and mid-computation reset.
module tb_pid_core_mc;
  localparam int W_IN = 18, W_OUT = 32, W_COEF = 16, N_CH = 6, W_CH = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [W_CH-1:0] param_chan;
  logic signed [W_COEF-1:0] sp_in, p_in, i_in, d_in;
  logic param_wr, update, clear;

  always #5 clk = ~clk;

  pid_core_mc_if #(.W_IN(W_IN), .W_OUT(W_OUT), .W_CH(W_CH)) bus ();

  pid_core_mc #(
    .W_IN(W_IN), .W_OUT(W_OUT), .W_COEF(W_COEF), .N_CH(N_CH), .W_CH(W_CH),
    .OUT_MAX(32'sd1000), .OUT_MIN(-32'sd1000)
  ) dut (
    .clk_in(clk), .reset_n_in(rst_n), .bus(bus),
    .param_chan_in(param_chan), .setpoint_in(sp_in), .p_coef_in(p_in),
    .i_coef_in(i_in), .d_coef_in(d_in),
    .param_wr_in(param_wr), .update_in(update), .clear_in(clear)
  );

  typedef struct {
    int     ch;
    longint exp_out;
    bit     exp_sat;
  } exp_t;

  typedef struct {
    bit     wr;
    int     sp, p, i, d;
    int     ch, data;
    longint exp_out;
    bit     exp_sat;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[14];
  int checks = 0, failures = 0, out_count = 0, base;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Scoreboard side: every strobe must match the oldest expected result
  always @(negedge clk) begin
    if (rst_n && bus.data_valid_out === 1'b1) begin
      out_count++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_strobe_chan", longint'(bus.chan_out), -1);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("data_out", longint'($signed(bus.data_out)), mon_e.exp_out);
        checkOutput("chan_out", longint'(bus.chan_out), longint'(mon_e.ch));
        checkOutput("sat_out", longint'(bus.sat_out), longint'(mon_e.exp_sat));
      end
    end
  end

  task automatic paramWrite(input int ch, input int sp, input int p, input int i, input int d);
    param_chan = W_CH'(ch);
    sp_in = W_COEF'(sp);  p_in = W_COEF'(p);  i_in = W_COEF'(i);  d_in = W_COEF'(d);
    param_wr = 1'b1;
    @(posedge clk); #1;
    param_wr = 1'b0;
  endtask

  task automatic pulseUpdate();
    update = 1'b1;
    @(posedge clk); #1;
    update = 1'b0;
  endtask

  // Waits (bounded) for ready, then holds valid for exactly the accepting edge
  task automatic sendSample(input int ch, input int data);
    int n = 0;
    while (bus.ready_out !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) checkOutput("ready_timeout", longint'(bus.ready_out), 1);
    bus.chan_in = W_CH'(ch);
    bus.data_in = W_IN'(data);
    bus.data_valid_in = 1'b1;
    @(posedge clk); #1;
    bus.data_valid_in = 1'b0;
  endtask

  task automatic applyStimulus(input int ch, input int data, input longint exp_out, input bit exp_sat);
    exp_t e;
    e.ch = ch;  e.exp_out = exp_out;  e.exp_sat = exp_sat;
    sb.push_back(e);
    sendSample(ch, data);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("drain_timeout_pending", longint'(sb.size()), 0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 100, 2, 1, 0,      0, 90,     30,    1'b0};
    vecs[1]  = '{1'b0, 0, 0, 0, 0,        0, 90,     40,    1'b0};
    vecs[2]  = '{1'b0, 0, 0, 0, 0,        0, 90,     50,    1'b0};
    vecs[3]  = '{1'b1, 0, 0, 0, 1,        3, 0,      0,     1'b0};
    vecs[4]  = '{1'b0, 0, 0, 0, 0,        3, 10,     -10,   1'b0};
    vecs[5]  = '{1'b0, 0, 0, 0, 0,        3, 0,      10,    1'b0};
    vecs[6]  = '{1'b0, 0, 0, 0, 0,        3, 0,      0,     1'b0};
    vecs[7]  = '{1'b0, 0, 0, 0, 0,        0, 90,     60,    1'b0};
    vecs[8]  = '{1'b1, 32767, 0, 32767, 0, 1, 0,     1000,  1'b1};
    vecs[9]  = '{1'b1, 0, 0, 32767, 0,    1, 1,      -1000, 1'b1};
    vecs[10] = '{1'b1, 0, 0, 1, 0,        1, 0,      -1000, 1'b0};
    vecs[11] = '{1'b0, 0, 0, 0, 0,        1, 1,      -1000, 1'b1};
    vecs[12] = '{1'b1, -32768, 1, 0, 0,   4, 262143, -1000, 1'b1};
    vecs[13] = '{1'b1, 32767, 1, 0, 0,    4, 0,      1000,  1'b1};

    rst_n = 1'b0;
    bus.data_in = '0;  bus.chan_in = '0;  bus.data_valid_in = 1'b0;
    param_chan = '0;  sp_in = '0;  p_in = '0;  i_in = '0;  d_in = '0;
    param_wr = 1'b0;  update = 1'b0;  clear = 1'b0;

    #12;
    checkOutput("reset_ready", longint'(bus.ready_out), 0);
    checkOutput("reset_data_out", longint'($signed(bus.data_out)), 0);
    checkOutput("reset_valid", longint'(bus.data_valid_out), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_ready", longint'(bus.ready_out), 1);

    for (int r = 0; r < 14; r++) begin
      if (vecs[r].wr) begin
        paramWrite(vecs[r].ch, vecs[r].sp, vecs[r].p, vecs[r].i, vecs[r].d);
        pulseUpdate();
      end
      applyStimulus(vecs[r].ch, vecs[r].data, vecs[r].exp_out, vecs[r].exp_sat);
      waitDrain();
    end

    $display("[TB] commit deferred while ch2 is in MAC1");
    paramWrite(2, 0, 1, 0, 0);
    pulseUpdate();
    applyStimulus(2, 5, -5, 1'b0);
    waitDrain();
    paramWrite(2, 0, 3, 0, 0);
    applyStimulus(2, 7, -7, 1'b0);
    repeat (2) @(posedge clk);
    #1 update = 1'b1;
    @(posedge clk); #1 update = 1'b0;
    waitDrain();
    applyStimulus(2, 0, 14, 1'b0);
    waitDrain();

    $display("[TB] back-to-back ch0 then ch1");
    applyStimulus(0, 90, 70, 1'b0);
    bus.chan_in = W_CH'(1);
    bus.data_in = '0;
    bus.data_valid_in = 1'b1;
    sb.push_back('{1, -1000, 1'b0});
    for (int k = 0; k < 6; k++) begin
      checkOutput("busy_ready_low", longint'(bus.ready_out), 0);
      if (k == 4) checkOutput("strobe_not_early", longint'(bus.data_valid_out), 0);
      if (k == 5) checkOutput("strobe_latency", longint'(bus.data_valid_out), 1);
      @(posedge clk); #1;
    end
    checkOutput("ready_after_7", longint'(bus.ready_out), 1);
    @(posedge clk); #1;
    bus.data_valid_in = 1'b0;
    checkOutput("second_accepted", longint'(bus.ready_out), 0);
    waitDrain();

    $display("[TB] out-of-range channel tag");
    base = out_count;
    sendSample(6, 123);
    checkOutput("badchan_load_ready", longint'(bus.ready_out), 0);
    @(posedge clk); #1;
    checkOutput("badchan_back_idle", longint'(bus.ready_out), 1);
    repeat (10) @(posedge clk);
    #1 checkOutput("badchan_no_strobe", longint'(out_count - base), 0);

    $display("[TB] clear during SEND");
    applyStimulus(0, 90, 80, 1'b0);
    repeat (5) @(posedge clk);
    #1 clear = 1'b1;
    checkOutput("clear_send_strobe", longint'(bus.data_valid_out), 1);
    @(posedge clk); #1 clear = 1'b0;
    waitDrain();
    applyStimulus(0, 90, 30, 1'b0);
    waitDrain();

    $display("[TB] reset during MAC0");
    base = out_count;
    sendSample(0, 90);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midreset_ready", longint'(bus.ready_out), 0);
    checkOutput("midreset_valid", longint'(bus.data_valid_out), 0);
    checkOutput("midreset_data_out", longint'($signed(bus.data_out)), 0);
    checkOutput("midreset_chan_out", longint'(bus.chan_out), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1 checkOutput("midreset_no_strobe", longint'(out_count - base), 0);
    paramWrite(0, 0, 1, 1, 0);
    applyStimulus(0, 90, 0, 1'b0);
    waitDrain();
    pulseUpdate();
    applyStimulus(0, 90, -90, 1'b0);
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
